// File: rtl/sysmem_icb_splitter_pkg.sv
// Shared definitions for the sysmem ICB splitter: id encoding, clog2 helper
// and the default SoC memory map for the downstream channels.
package sysmem_icb_splitter_pkg;

  localparam logic [31:0] SOC_SRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] SOC_SRAM_MASK = 32'hF000_0000;
  localparam logic [31:0] SOC_DDR_BASE  = 32'h9000_0000;
  localparam logic [31:0] SOC_DDR_MASK  = 32'hF000_0000;
  localparam logic [31:0] SOC_FB_BASE   = 32'hA000_0000;
  localparam logic [31:0] SOC_FB_MASK   = 32'hF000_0000;

  function automatic int icb_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // The error responder takes the id just past the last real channel.
  function automatic int icb_err_id(input int ch_num);
    return ch_num;
  endfunction

endpackage

// File: rtl/sysmem_icb_splitter_icb_ord_fifo.sv
// Order FIFO remembering which channel owns each outstanding transaction.
// Pointers wrap naturally because DEPTH is a power of two.
module icb_ord_fifo
  import sysmem_icb_splitter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [icb_clog2(DEPTH):0]  count
);

  localparam int PW = icb_clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, only the written slot changes.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sysmem_icb_splitter.sv
// 1-to-N ICB splitter for the system-memory port: address decode to CH_NUM
// slaves plus an internal error responder, with in-order response return.
module sysmem_icb_splitter
  import sysmem_icb_splitter_pkg::*;
#(
  parameter int                   CH_NUM     = 4,
  parameter int                   AW         = 32,
  parameter int                   DW         = 32,
  parameter int                   OUTS_DEPTH = 4,
  parameter logic [CH_NUM*AW-1:0] CH_BASE    = '0,
  parameter logic [CH_NUM*AW-1:0] CH_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_icb_cmd_valid,
  output logic                           s_icb_cmd_ready,
  input  logic [AW-1:0]                  s_icb_cmd_addr,
  input  logic                           s_icb_cmd_read,
  input  logic [DW-1:0]                  s_icb_cmd_wdata,
  input  logic [DW/8-1:0]                s_icb_cmd_wmask,
  output logic                           s_icb_rsp_valid,
  input  logic                           s_icb_rsp_ready,
  output logic                           s_icb_rsp_err,
  output logic [DW-1:0]                  s_icb_rsp_rdata,
  output logic [CH_NUM-1:0]              m_icb_cmd_valid,
  input  logic [CH_NUM-1:0]              m_icb_cmd_ready,
  output logic [AW-1:0]                  m_icb_cmd_addr,
  output logic                           m_icb_cmd_read,
  output logic [DW-1:0]                  m_icb_cmd_wdata,
  output logic [DW/8-1:0]                m_icb_cmd_wmask,
  input  logic [CH_NUM-1:0]              m_icb_rsp_valid,
  output logic [CH_NUM-1:0]              m_icb_rsp_ready,
  input  logic [CH_NUM-1:0]              m_icb_rsp_err,
  input  logic [CH_NUM*DW-1:0]           m_icb_rsp_rdata,
  output logic [icb_clog2(OUTS_DEPTH):0] outs_cnt,
  output logic                           dec_err
);

  localparam int ERR_ID = icb_err_id(CH_NUM);
  localparam int IDW    = icb_clog2(CH_NUM + 1);

  logic [IDW-1:0] sel_s;
  logic [IDW-1:0] head_s;
  logic           is_err_s;
  logic           sel_ready_s;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;

  // Address decode: walking from the top index down lets the lowest hit win.
  always_comb begin
    sel_s = IDW'(ERR_ID);
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if ((s_icb_cmd_addr & CH_MASK[i*AW +: AW]) ==
          (CH_BASE[i*AW +: AW] & CH_MASK[i*AW +: AW])) begin
        sel_s = IDW'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  assign is_err_s = (sel_s == IDW'(ERR_ID));

  // Command steering; the error responder always accepts.
  always_comb begin
    m_icb_cmd_valid = {CH_NUM{1'b0}};
    sel_ready_s     = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      if (sel_s == IDW'(i)) begin
        m_icb_cmd_valid[i] = s_icb_cmd_valid & ~full_s;
        sel_ready_s        = m_icb_cmd_ready[i];
      end else begin
        m_icb_cmd_valid[i] = 1'b0;
      end
    end
  end

  assign s_icb_cmd_ready = ~full_s & sel_ready_s;
  assign push_s          = s_icb_cmd_valid & s_icb_cmd_ready;

  assign m_icb_cmd_addr  = s_icb_cmd_addr;
  assign m_icb_cmd_read  = s_icb_cmd_read;
  assign m_icb_cmd_wdata = s_icb_cmd_wdata;
  assign m_icb_cmd_wmask = s_icb_cmd_wmask;

  icb_ord_fifo #(
    .DEPTH (OUTS_DEPTH),
    .WIDTH (IDW)
  ) u_ord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (sel_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (outs_cnt)
  );

  // Response mux: only the channel at the head of the order FIFO sees ready.
  always_comb begin
    s_icb_rsp_valid = 1'b0;
    s_icb_rsp_err   = 1'b0;
    s_icb_rsp_rdata = {DW{1'b0}};
    m_icb_rsp_ready = {CH_NUM{1'b0}};
    if (empty_s) begin
      s_icb_rsp_valid = 1'b0;
    end else if (head_s == IDW'(ERR_ID)) begin
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_err   = 1'b1;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (head_s == IDW'(i)) begin
          s_icb_rsp_valid    = m_icb_rsp_valid[i];
          s_icb_rsp_err      = m_icb_rsp_err[i];
          s_icb_rsp_rdata    = m_icb_rsp_rdata[i*DW +: DW];
          m_icb_rsp_ready[i] = s_icb_rsp_ready;
        end else begin
          m_icb_rsp_ready[i] = 1'b0;
        end
      end
    end
  end

  assign pop_s = s_icb_rsp_valid & s_icb_rsp_ready;

  // Decode-error pulse, one cycle after an unmatched command is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_err <= 1'b0;
    end else begin
      dec_err <= push_s & is_err_s;
    end
  end

endmodule

// File: tb/tb_sysmem_icb_splitter.sv
// Randomized and directed bench for sysmem_icb_splitter against a queue-based
// model of command order and per-slave pending responses.
module tb_sysmem_icb_splitter;

  localparam int CH    = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int ERR   = CH;

  localparam logic [CH*AW-1:0] BASES = {32'h8000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000};
  localparam logic [CH*AW-1:0] MASKS = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_icb_cmd_valid;
  logic              s_icb_cmd_ready;
  logic [AW-1:0]     s_icb_cmd_addr;
  logic              s_icb_cmd_read;
  logic [DW-1:0]     s_icb_cmd_wdata;
  logic [DW/8-1:0]   s_icb_cmd_wmask;
  logic              s_icb_rsp_valid;
  logic              s_icb_rsp_ready;
  logic              s_icb_rsp_err;
  logic [DW-1:0]     s_icb_rsp_rdata;
  logic [CH-1:0]     m_icb_cmd_valid;
  logic [CH-1:0]     m_icb_cmd_ready;
  logic [AW-1:0]     m_icb_cmd_addr;
  logic              m_icb_cmd_read;
  logic [DW-1:0]     m_icb_cmd_wdata;
  logic [DW/8-1:0]   m_icb_cmd_wmask;
  logic [CH-1:0]     m_icb_rsp_valid;
  logic [CH-1:0]     m_icb_rsp_ready;
  logic [CH-1:0]     m_icb_rsp_err;
  logic [CH*DW-1:0]  m_icb_rsp_rdata;
  logic [2:0]        outs_cnt;
  logic              dec_err;

  always #5 clk = ~clk;

  sysmem_icb_splitter #(
    .CH_NUM(CH), .AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH), .CH_BASE(BASES), .CH_MASK(MASKS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
    .outs_cnt(outs_cnt), .dec_err(dec_err)
  );

  // Memory map as the bench understands it (channel 3 overlaps 0..2 on purpose).
  logic [31:0] tb_base [CH] = '{32'h8000_0000, 32'h9000_0000, 32'hA000_0000, 32'h8000_0000};
  logic [31:0] tb_mask [CH] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hC000_0000};

  int          checks = 0;
  int          errors = 0;
  int          ord_q[$];
  logic [32:0] slv_q [CH][$];
  logic [CH-1:0] slv_en;
  logic        dec_exp;
  bit          cfire;
  bit          rfire;
  int          cur_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < CH; i++) begin
      if ((a & tb_mask[i]) == (tb_base[i] & tb_mask[i])) return i;
    end
    return ERR;
  endfunction

  task automatic idle();
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = 32'h0;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = 32'h0;
    s_icb_cmd_wmask = 4'h0;
    s_icb_rsp_ready = 1'b1;
    m_icb_cmd_ready = {CH{1'b1}};
    slv_en          = {CH{1'b1}};
  endtask

  task automatic send(input logic [31:0] a, input logic rd);
    s_icb_cmd_valid = 1'b1;
    s_icb_cmd_addr  = a;
    s_icb_cmd_read  = rd;
    s_icb_cmd_wdata = $urandom;
    s_icb_cmd_wmask = 4'($urandom);
  endtask

  // Present slave responses, then compare every DUT output with the model.
  task automatic drive_and_check();
    logic          full, exp_cr, exp_rv, exp_err;
    logic [31:0]   exp_rd;
    logic [CH-1:0] exp_mv, exp_mr;
    int            h;
    for (int i = 0; i < CH; i++) begin
      m_icb_rsp_valid[i] = slv_en[i] && (slv_q[i].size() > 0);
      m_icb_rsp_err[i]   = (slv_q[i].size() > 0) ? slv_q[i][0][32] : 1'($urandom);
      m_icb_rsp_rdata[i*DW +: DW] = (slv_q[i].size() > 0) ? slv_q[i][0][31:0] : 32'($urandom);
    end
    #1;
    cur_ch = decode(s_icb_cmd_addr);
    full   = (ord_q.size() == DEPTH);
    exp_mv = '0;
    if (s_icb_cmd_valid && !full && cur_ch < CH) exp_mv[cur_ch] = 1'b1;
    if (cur_ch == ERR) exp_cr = !full;
    else               exp_cr = !full && m_icb_cmd_ready[cur_ch];
    exp_rv = 1'b0; exp_err = 1'b0; exp_rd = 32'h0; exp_mr = '0;
    if (ord_q.size() > 0) begin
      h = ord_q[0];
      if (h == ERR) begin
        exp_rv  = 1'b1;
        exp_err = 1'b1;
      end else begin
        exp_rv    = m_icb_rsp_valid[h];
        exp_mr[h] = s_icb_rsp_ready;
        if (exp_rv) begin
          exp_err = slv_q[h][0][32];
          exp_rd  = slv_q[h][0][31:0];
        end
      end
    end
    chk("m_cmd_valid", 64'(m_icb_cmd_valid), 64'(exp_mv));
    chk("s_cmd_ready", 64'(s_icb_cmd_ready), 64'(exp_cr));
    chk("s_rsp_valid", 64'(s_icb_rsp_valid), 64'(exp_rv));
    chk("m_rsp_ready", 64'(m_icb_rsp_ready), 64'(exp_mr));
    chk("outs_cnt", 64'(outs_cnt), 64'(ord_q.size()));
    chk("dec_err", 64'(dec_err), 64'(dec_exp));
    chk("m_cmd_addr", 64'(m_icb_cmd_addr), 64'(s_icb_cmd_addr));
    if (ord_q.size() == 0 || exp_rv) begin
      chk("s_rsp_err", 64'(s_icb_rsp_err), 64'(exp_err));
      chk("s_rsp_rdata", 64'(s_icb_rsp_rdata), 64'(exp_rd));
    end
    cfire = s_icb_cmd_valid && exp_cr;
    rfire = exp_rv && s_icb_rsp_ready;
  endtask

  // Advance one clock and apply the handshakes seen in drive_and_check.
  task automatic commit();
    int          h;
    logic [32:0] e;
    @(posedge clk);
    if (!rst_n) begin
      ord_q.delete();
      for (int i = 0; i < CH; i++) slv_q[i].delete();
      dec_exp = 1'b0;
    end else begin
      if (rfire) begin
        h = ord_q.pop_front();
        if (h < CH) void'(slv_q[h].pop_front());
      end
      if (cfire) begin
        ord_q.push_back(cur_ch);
        if (cur_ch < CH) begin
          e[31:0] = $urandom;
          e[32]   = ($urandom_range(3, 0) == 0);
          slv_q[cur_ch].push_back(e);
        end
      end
      dec_exp = cfire && (cur_ch == ERR);
    end
    #1;
  endtask

  task automatic cycle();
    drive_and_check();
    commit();
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 40 && ord_q.size() > 0; n++) cycle();
    chk("drain_empty", 64'(ord_q.size()), 64'd0);
  endtask

  initial begin
    logic [3:0]  top;
    logic [31:0] rnd;
    idle();
    dec_exp = 1'b0;
    rst_n   = 1'b0;
    m_icb_rsp_valid = '0;
    m_icb_rsp_err   = '0;
    m_icb_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_and_check();
    chk("rst_cmd_ready", 64'(s_icb_cmd_ready), 64'd1);
    chk("rst_outs_cnt", 64'(outs_cnt), 64'd0);
    commit();

    // Read to CH0 with a known response word.
    send(32'h8000_0010, 1'b1);
    slv_en = 4'b0000;
    drive_and_check();
    chk("t1_mcv", 64'(m_icb_cmd_valid), 64'h1);
    commit();
    idle();
    slv_q[0][0] = {1'b0, 32'hDEAD_BEEF};
    drive_and_check();
    chk("t1_cnt", 64'(outs_cnt), 64'd1);
    chk("t1_rdata", 64'(s_icb_rsp_rdata), 64'hDEAD_BEEF);
    commit();
    drive_and_check();
    chk("t1_cnt_end", 64'(outs_cnt), 64'd0);
    commit();

    // Unmatched write goes to the error responder.
    send(32'h1000_0000, 1'b0);
    drive_and_check();
    chk("t2_ready", 64'(s_icb_cmd_ready), 64'd1);
    chk("t2_mcv", 64'(m_icb_cmd_valid), 64'h0);
    commit();
    idle();
    drive_and_check();
    chk("t2_dec_err", 64'(dec_err), 64'd1);
    chk("t2_rsp", 64'({s_icb_rsp_valid, s_icb_rsp_err}), 64'b11);
    chk("t2_rdata", 64'(s_icb_rsp_rdata), 64'h0);
    commit();
    cycle();

    // CH1 then CH0; CH0 answers first but must wait its turn.
    slv_en = 4'b1101;
    send(32'h9000_0040, 1'b1);
    cycle();
    slv_q[1][0] = {1'b0, 32'h1111_AAAA};
    send(32'h8000_0080, 1'b1);
    cycle();
    slv_q[0][0] = {1'b0, 32'h2222_BBBB};
    s_icb_cmd_valid = 1'b0;
    repeat (2) begin
      drive_and_check();
      chk("t3_hold", 64'(m_icb_rsp_ready[0]), 64'd0);
      commit();
    end
    slv_en = 4'b1111;
    drive_and_check();
    chk("t3_first", 64'(s_icb_rsp_rdata), 64'h1111_AAAA);
    commit();
    drive_and_check();
    chk("t3_second", 64'(s_icb_rsp_rdata), 64'h2222_BBBB);
    commit();
    drain();

    // Fill to OUTS_DEPTH, check the stall, then free one slot.
    slv_en = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      send(32'hA000_0000 + 32'(i * 4), 1'b1);
      cycle();
    end
    send(32'hA000_0100, 1'b1);
    drive_and_check();
    chk("t4_full_cnt", 64'(outs_cnt), 64'd4);
    chk("t4_stall", 64'(s_icb_cmd_ready), 64'd0);
    commit();
    slv_en = 4'b0100;
    drive_and_check();
    chk("t4_no_bypass", 64'(s_icb_cmd_ready), 64'd0);
    commit();
    slv_en = 4'b0000;
    drive_and_check();
    chk("t4_ready_back", 64'(s_icb_cmd_ready), 64'd1);
    commit();
    drain();

    // Back-to-back with zero-wait slaves holds one in flight.
    for (int i = 0; i < 8; i++) begin
      send(32'h8000_0000 + 32'(i * 4), 1'b1);
      drive_and_check();
      if (i > 0) chk("t5_steady", 64'(outs_cnt), 64'd1);
      commit();
    end
    drain();

    // Reset with three outstanding transactions.
    slv_en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      send(32'h9000_0000 + 32'(i * 4), 1'b1);
      cycle();
    end
    idle();
    slv_en = 4'b0000;
    rst_n  = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive_and_check();
    chk("t6_cnt", 64'(outs_cnt), 64'd0);
    chk("t6_rsp", 64'({s_icb_rsp_valid, m_icb_rsp_ready}), 64'h0);
    commit();
    slv_en = 4'b1111;
    send(32'h9000_0200, 1'b0);
    drive_and_check();
    chk("t6_route", 64'(m_icb_cmd_valid), 64'h2);
    commit();
    drain();

    // Random traffic, long enough to wrap the pointers many times.
    for (int n = 0; n < 800; n++) begin
      rnd = $urandom;
      case ($urandom_range(4, 0))
        0:       top = 4'h8;
        1:       top = 4'h9;
        2:       top = 4'hA;
        3:       top = 4'hB;
        default: top = 4'($urandom_range(7, 0));
      endcase
      if ($urandom_range(9, 0) < 7) send({top, rnd[27:0]}, 1'($urandom));
      else s_icb_cmd_valid = 1'b0;
      s_icb_rsp_ready = ($urandom_range(3, 0) != 0);
      m_icb_cmd_ready = 4'($urandom);
      slv_en          = 4'($urandom);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
